// File: rtl/spi_flash_pkg.sv
// Shared opcodes, status bit positions and FSM state encoding for spi_flash_responder.
package spi_flash_pkg;

    localparam logic [7:0] READ_DATA       = 8'h03;
    localparam logic [7:0] PAGE_PROGRAM    = 8'h02;
    localparam logic [7:0] READ_STATUS_REG = 8'h05;
    localparam logic [7:0] WRITE_ENABLE    = 8'h06;
    localparam logic [7:0] WRITE_DISABLE   = 8'h04;
    localparam logic [7:0] RESET_ENABLE    = 8'h66;
    localparam logic [7:0] RESET_DEVICE    = 8'h99;
    localparam logic [7:0] FAST_READ       = 8'h0B;

    localparam int WIP = 0;
    localparam int WEL = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_READ,
        ST_PROG,
        ST_STATUS,
        ST_PEND,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/spi_flash_responder_shifter.sv
// SPI mode-0 slave front end: pin synchronizers, edge detection, RX byte assembly
// and TX byte serialization in the clk domain.
module spi_slave_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       cs_n_i,
    input  logic [7:0] tx_byte_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       cs_fall_o,
    output logic       cs_rise_o,
    output logic       miso_o
);

    // index 1 is the synchronized level, index 2 the previous one for edge detection
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic [2:0] bit_cnt_q;
    logic       rx_valid_q;
    logic       miso_q;
    logic [7:0] rx_sh_q;
    logic [7:0] tx_sh_q;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_low;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_low    = ~cs_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q     <= 3'b000;
            cs_q       <= 3'b111;
            mosi_q     <= 2'b00;
            bit_cnt_q  <= 3'd0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            sclk_q     <= {sclk_q[1:0], sclk_i};
            cs_q       <= {cs_q[1:0], cs_n_i};
            mosi_q     <= {mosi_q[0], mosi_i};
            rx_valid_q <= 1'b0;
            if (!cs_low) begin
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                    rx_valid_q <= (bit_cnt_q == 3'd7);
                end
                // a falling edge with the counter at 0 starts a new response byte
                if (sclk_fall) begin
                    miso_q <= (bit_cnt_q == 3'd0) ? tx_byte_i[7] : tx_sh_q[7];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!cs_low) begin
            tx_sh_q <= 8'h00;
        end else begin
            if (sclk_rise) begin
                rx_sh_q <= {rx_sh_q[6:0], mosi_q[1]};
            end
            if (sclk_fall) begin
                tx_sh_q <= (bit_cnt_q == 3'd0) ? {tx_byte_i[6:0], 1'b0} : {tx_sh_q[6:0], 1'b0};
            end
        end
    end

    assign rx_byte_o  = rx_sh_q;
    assign rx_valid_o = rx_valid_q;
    assign cs_fall_o  = cs_low & cs_q[2];
    assign cs_rise_o  = cs_q[1] & ~cs_q[2];
    assign miso_o     = miso_q;

endmodule

// File: rtl/spi_flash_responder.sv
// Serial NOR flash model behind an SPI slave with a backdoor port into its byte array.
// Define SPI_FLASH_RESP_FAST_READ_EN to decode FAST_READ (0x0B) with one dummy byte.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int PROG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic              spi_miso,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata,
    output logic [7:0]        status
);

    localparam int TW = (PROG_CYCLES < 2) ? 1 : $clog2(PROG_CYCLES + 1);

    logic [7:0]  mem [2**ADDR_W];
    logic [7:0]  mem_rdata_q;
    logic [7:0]  bd_rdata_q;

    state_e      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  acnt_q, acnt_d;
    logic        armed_q, armed_d;
    logic        wel_q, wel_d;
    logic        wip_q, wip_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        prog_wr_q, prog_wr_d;
    logic        spi_we;

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        cs_fall;
    logic        cs_rise;
    logic [7:0]  tx_byte;

    spi_slave_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .sclk_i     (spi_clk),
        .mosi_i     (spi_mosi),
        .cs_n_i     (spi_cs_n),
        .tx_byte_i  (tx_byte),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .cs_fall_o  (cs_fall),
        .cs_rise_o  (cs_rise),
        .miso_o     (spi_miso)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= 24'h0;
            op_q      <= 8'h00;
            acnt_q    <= 2'd0;
            armed_q   <= 1'b0;
            wel_q     <= 1'b0;
            wip_q     <= 1'b0;
            timer_q   <= '0;
            prog_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            acnt_q    <= acnt_d;
            armed_q   <= armed_d;
            wel_q     <= wel_d;
            wip_q     <= wip_d;
            timer_q   <= timer_d;
            prog_wr_q <= prog_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        acnt_d    = acnt_q;
        armed_d   = armed_q;
        wel_d     = wel_q;
        wip_d     = wip_q;
        timer_d   = timer_q;
        prog_wr_d = prog_wr_q;
        spi_we    = 1'b0;

        if (wip_q) begin
            if (timer_q <= TW'(1)) begin
                wip_d   = 1'b0;
                wel_d   = 1'b0;
                timer_d = '0;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end

        if (cs_rise) begin
            state_d = ST_IDLE;
            if (state_q == ST_PEND) begin
                case (op_q)
                    WRITE_ENABLE:  wel_d = 1'b1;
                    WRITE_DISABLE: wel_d = 1'b0;
                    RESET_ENABLE:  armed_d = 1'b1;
                    RESET_DEVICE: begin
                        if (armed_q) begin
                            wel_d   = 1'b0;
                            wip_d   = 1'b0;
                            timer_d = '0;
                        end
                        armed_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            if (state_q == ST_PROG && prog_wr_q) begin
                wip_d   = 1'b1;
                timer_d = TW'(PROG_CYCLES);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        prog_wr_d = 1'b0;
                        acnt_d    = 2'd0;
                    end
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        op_d = rx_byte;
                        if (rx_byte != RESET_DEVICE) begin
                            armed_d = 1'b0;
                        end
                        // a busy device still answers status polls and the reset pair
                        if (wip_q && rx_byte != READ_STATUS_REG &&
                            rx_byte != RESET_ENABLE && rx_byte != RESET_DEVICE) begin
                            state_d = ST_IGNORE;
                        end else begin
                            case (rx_byte)
                                READ_DATA:       state_d = ST_ADDR;
                                PAGE_PROGRAM:    state_d = wel_q ? ST_ADDR : ST_IGNORE;
                                READ_STATUS_REG: state_d = ST_STATUS;
                                WRITE_ENABLE, WRITE_DISABLE,
                                RESET_ENABLE, RESET_DEVICE: state_d = ST_PEND;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                                FAST_READ:       state_d = ST_ADDR;
`endif
                                default:         state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_d = {addr_q[15:0], rx_byte};
                        acnt_d = acnt_q + 2'd1;
                        if (acnt_q == 2'd2) begin
                            case (op_q)
                                READ_DATA:    state_d = ST_READ;
                                PAGE_PROGRAM: state_d = ST_PROG;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
                                FAST_READ:    state_d = ST_DUMMY;
`endif
                                default:      state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rx_valid) begin
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (rx_valid) begin
                        addr_d = addr_q + 24'd1;
                    end
                end
                ST_PROG: begin
                    if (rx_valid) begin
                        spi_we    = 1'b1;
                        prog_wr_d = 1'b1;
                        addr_d    = {addr_q[23:8], addr_q[7:0] + 8'd1};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            ST_READ:   tx_byte = mem_rdata_q;
            ST_STATUS: tx_byte = status;
            default:   tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        status      = 8'h00;
        status[WIP] = wip_q;
        status[WEL] = wel_q;
    end

    // backdoor write wins; a colliding SPI write is dropped
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end else if (spi_we) begin
            mem[addr_q[ADDR_W-1:0]] <= rx_byte;
        end
        mem_rdata_q <= mem[addr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bd_rdata_q <= 8'h00;
        end else begin
            bd_rdata_q <= mem[bd_addr];
        end
    end

    assign bd_rdata = bd_rdata_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI transactions plus backdoor preload/inspect.
module tb_spi_flash_responder;

    localparam int ADDR_W   = 10;
    localparam int PROG_CYC = 600;
    localparam int HALF     = 60;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_cs_n;
    logic              spi_miso;
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [7:0]        bd_wdata;
    logic [7:0]        bd_rdata;
    logic [7:0]        status;

    int errors = 0;
    int checks = 0;

    spi_flash_responder #(.ADDR_W(ADDR_W), .PROG_CYCLES(PROG_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_cs_n (spi_cs_n),
        .spi_miso (spi_miso),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata),
        .status   (status)
    );

    always #5 clk = ~clk;

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #HALF;
            r[i] = spi_miso;
            spi_clk = 1'b1;
            #HALF;
            spi_clk = 1'b0;
        end
        rx = r;
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            #HALF;
            spi_clk = 1'b1;
            #HALF;
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_stop();
        #HALF;
        spi_cs_n = 1'b1;
        #100;
    endtask

    task automatic cmd1(input logic [7:0] op);
        logic [7:0] r;
        cs_start();
        xfer(op, r);
        cs_stop();
    endtask

    task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bd_addr  = a;
        bd_wdata = d;
        bd_we    = 1'b1;
        #10;
        bd_we    = 1'b0;
    endtask

    task automatic bd_read(input logic [ADDR_W-1:0] a, output logic [7:0] d);
        bd_addr = a;
        #20;
        d = bd_rdata;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2 * PROG_CYC && status[0]; i++) #10;
        checks++;
        if (status[0] !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: WIP still %b, expected 0 within bound", status[0]);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_wdata = 8'h00;
        #20;
        checks++;
        if (status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", status); end
        checks++;
        if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
        checks++;
        if (bd_rdata !== 8'h00) begin errors++; $display("FAIL reset_bd_rdata: got %h expected 00", bd_rdata); end
        rst = 1'b0;
        #20;
    endtask

    task automatic test_read();
        logic [7:0] r;
        bd_write(10'h100, 8'hA5);
        bd_write(10'h101, 8'h3C);
        cs_start();
        xfer(8'h03, r);
        xfer(8'h00, r);
        xfer(8'h01, r);
        xfer(8'h00, r);
        checks++;
        if (r !== 8'h00) begin errors++; $display("FAIL read_addr_phase_miso: got %h expected 00", r); end
        xfer(8'h00, r);
        checks++;
        if (r !== 8'hA5) begin errors++; $display("FAIL read_byte0: got %h expected A5", r); end
        xfer(8'h00, r);
        checks++;
        if (r !== 8'h3C) begin errors++; $display("FAIL read_byte1: got %h expected 3C", r); end
        cs_stop();
    endtask

    task automatic test_program();
        logic [7:0] r;
        cmd1(8'h06);
        cs_start();
        xfer(8'h05, r);
        xfer(8'h00, r);
        cs_stop();
        checks++;
        if (r !== 8'h02) begin errors++; $display("FAIL wren_status: got %h expected 02", r); end
        cs_start();
        xfer(8'h02, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'h10, r);
        xfer(8'hDE, r);
        xfer(8'hAD, r);
        #HALF;
        spi_cs_n = 1'b1;
        #20;
        checks++;
        if (status !== 8'h02) begin errors++; $display("FAIL wip_not_yet: got %h expected 02", status); end
        #10;
        checks++;
        if (status !== 8'h03) begin errors++; $display("FAIL wip_set: got %h expected 03", status); end
        #(10 * PROG_CYC - 10);
        checks++;
        if (status !== 8'h03) begin errors++; $display("FAIL wip_last_cycle: got %h expected 03", status); end
        #10;
        checks++;
        if (status !== 8'h00) begin errors++; $display("FAIL wip_cleared: got %h expected 00", status); end
        bd_read(10'h010, r);
        checks++;
        if (r !== 8'hDE) begin errors++; $display("FAIL prog_byte0: got %h expected DE", r); end
        bd_read(10'h011, r);
        checks++;
        if (r !== 8'hAD) begin errors++; $display("FAIL prog_byte1: got %h expected AD", r); end
    endtask

    task automatic test_no_wel();
        logic [7:0] r;
        bd_write(10'h020, 8'h11);
        cs_start();
        xfer(8'h02, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'h20, r);
        xfer(8'h55, r);
        cs_stop();
        bd_read(10'h020, r);
        checks++;
        if (r !== 8'h11) begin errors++; $display("FAIL no_wel_mem: got %h expected 11", r); end
        checks++;
        if (status !== 8'h00) begin errors++; $display("FAIL no_wel_status: got %h expected 00", status); end
    endtask

    task automatic test_wip_block();
        logic [7:0] r;
        cmd1(8'h06);
        cs_start();
        xfer(8'h02, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'h30, r);
        xfer(8'h77, r);
        cs_stop();
        cs_start();
        xfer(8'h05, r);
        xfer(8'h00, r);
        cs_stop();
        checks++;
        if (r !== 8'h03) begin errors++; $display("FAIL busy_status_read: got %h expected 03", r); end
        cs_start();
        xfer(8'h03, r);
        xfer(8'h00, r);
        xfer(8'h01, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        checks++;
        if (r !== 8'h00) begin errors++; $display("FAIL busy_read_ignored0: got %h expected 00", r); end
        xfer(8'h00, r);
        checks++;
        if (r !== 8'h00) begin errors++; $display("FAIL busy_read_ignored1: got %h expected 00", r); end
        cs_stop();
        wait_idle();
    endtask

    task automatic test_wrap();
        logic [7:0] r;
        bd_write(10'h3FF, 8'h5A);
        bd_write(10'h000, 8'hC3);
        cs_start();
        xfer(8'h03, r);
        xfer(8'h00, r);
        xfer(8'h03, r);
        xfer(8'hFF, r);
        xfer(8'h00, r);
        checks++;
        if (r !== 8'h5A) begin errors++; $display("FAIL wrap_read_top: got %h expected 5A", r); end
        xfer(8'h00, r);
        checks++;
        if (r !== 8'hC3) begin errors++; $display("FAIL wrap_read_zero: got %h expected C3", r); end
        cs_stop();
        cmd1(8'h06);
        cs_start();
        xfer(8'h02, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'hFF, r);
        xfer(8'h12, r);
        xfer(8'h34, r);
        cs_stop();
        wait_idle();
        bd_read(10'h0FF, r);
        checks++;
        if (r !== 8'h12) begin errors++; $display("FAIL page_wrap_0ff: got %h expected 12", r); end
        bd_read(10'h000, r);
        checks++;
        if (r !== 8'h34) begin errors++; $display("FAIL page_wrap_000: got %h expected 34", r); end
        bd_read(10'h100, r);
        checks++;
        if (r !== 8'hA5) begin errors++; $display("FAIL page_wrap_100: got %h expected A5", r); end
    endtask

    task automatic test_partial();
        logic [7:0] r;
        bd_write(10'h041, 8'hEE);
        cmd1(8'h06);
        cs_start();
        xfer(8'h02, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'h40, r);
        xfer(8'h66, r);
        xfer_bits(8'h99, 5);
        cs_stop();
        wait_idle();
        bd_read(10'h040, r);
        checks++;
        if (r !== 8'h66) begin errors++; $display("FAIL partial_full_byte: got %h expected 66", r); end
        bd_read(10'h041, r);
        checks++;
        if (r !== 8'hEE) begin errors++; $display("FAIL partial_dropped: got %h expected EE", r); end
    endtask

    task automatic test_reset_cmds();
        logic [7:0] r;
        cmd1(8'h06);
        cmd1(8'h04);
        checks++;
        if (status !== 8'h00) begin errors++; $display("FAIL wrdi_status: got %h expected 00", status); end
        cmd1(8'h06);
        cs_start();
        xfer(8'h02, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'h50, r);
        xfer(8'h5C, r);
        cs_stop();
        checks++;
        if (status !== 8'h03) begin errors++; $display("FAIL pre_reset_busy: got %h expected 03", status); end
        cmd1(8'h66);
        cmd1(8'h99);
        checks++;
        if (status !== 8'h00) begin errors++; $display("FAIL reset_during_wip: got %h expected 00", status); end
        bd_read(10'h050, r);
        checks++;
        if (r !== 8'h5C) begin errors++; $display("FAIL reset_keeps_mem: got %h expected 5C", r); end
        cmd1(8'h06);
        cmd1(8'h66);
        cs_start();
        xfer(8'h05, r);
        xfer(8'h00, r);
        cs_stop();
        checks++;
        if (r !== 8'h02) begin errors++; $display("FAIL disarm_status_read: got %h expected 02", r); end
        cmd1(8'h99);
        checks++;
        if (status !== 8'h02) begin errors++; $display("FAIL disarmed_reset: got %h expected 02", status); end
        cmd1(8'h04);
    endtask

    task automatic test_fast_read();
        logic [7:0] r;
        logic [7:0] e0;
        logic [7:0] e1;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
        e0 = 8'hA5;
        e1 = 8'h3C;
`else
        e0 = 8'h00;
        e1 = 8'h00;
`endif
        cs_start();
        xfer(8'h0B, r);
        xfer(8'h00, r);
        xfer(8'h01, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        xfer(8'h00, r);
        checks++;
        if (r !== e0) begin errors++; $display("FAIL fast_read_byte0: got %h expected %h", r, e0); end
        xfer(8'h00, r);
        checks++;
        if (r !== e1) begin errors++; $display("FAIL fast_read_byte1: got %h expected %h", r, e1); end
        cs_stop();
    endtask

    initial begin
        test_reset();
        test_read();
        test_program();
        test_no_wel();
        test_wip_block();
        test_wrap();
        test_partial();
        test_reset_cmds();
        test_fast_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
